datapath_dst_demux24: RTL and testbench

- Registered 2-to-4 fork/demux for paired-channel streams; the distribution counterpart of the 4-to-2 source join mux.
- One input beat carries two lanes (Z0, Z1). Select S routes Z0 and Z1 to two of four sinks (A, B, C, D).
- Each sink has a one-entry output register, so lanes complete independently and throughput is one beat per cycle.
- Sits between PE/array result lanes and downstream buffer writers.

---
 rtl/datapath_dst_demux24.sv | 108 ++++++++++
 tb/tb_datapath_dst_demux24.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_dst_demux24.sv
// datapath_dst_demux24: registered 2-to-4 fork for paired-lane streams.
// Each accepted beat writes lane Z0 and lane Z1 into two of the four sink
// registers (A..D) chosen by S. Every sink has a one-entry output register,
// so the sinks drain independently while the lanes of one beat stay paired.
module datapath_dst_demux24 #(
   parameter int unsigned DWID   = 24,
   parameter int unsigned CH_NUM = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [1:0]                     S,
   input  logic                           Z_valid,
   output logic                           Z_ready,
   input  logic [CH_NUM-1:0][DWID-1:0]    Z0_data,
   input  logic [CH_NUM-1:0][DWID-1:0]    Z1_data,
   output logic                           A_valid,
   output logic                           B_valid,
   output logic                           C_valid,
   output logic                           D_valid,
   input  logic                           A_ready,
   input  logic                           B_ready,
   input  logic                           C_ready,
   input  logic                           D_ready,
   output logic [CH_NUM-1:0][DWID-1:0]    A_data,
   output logic [CH_NUM-1:0][DWID-1:0]    B_data,
   output logic [CH_NUM-1:0][DWID-1:0]    C_data,
   output logic [CH_NUM-1:0][DWID-1:0]    D_data
);

   localparam int unsigned NSINK = 4;

   typedef logic [CH_NUM-1:0][DWID-1:0] lane_t;

   // Sink index order throughout: bit 0 = A, 1 = B, 2 = C, 3 = D.
   logic [NSINK-1:0] tgt0;      // one-hot sink receiving Z0
   logic [NSINK-1:0] tgt1;      // one-hot sink receiving Z1
   logic [NSINK-1:0] sink_rdy;
   logic [NSINK-1:0] free;
   logic [NSINK-1:0] load;
   logic             accept;

   logic [NSINK-1:0] valid_q;
   logic [NSINK-1:0] valid_d;
   lane_t            data_q [NSINK];
   lane_t            data_d [NSINK];

   assign sink_rdy = {D_ready, C_ready, B_ready, A_ready};

   // Route decode: S picks the sink pair for Z0/Z1; the two targets never coincide.
   always_comb begin
      tgt0 = 4'b0001;
      tgt1 = 4'b0010;
      case (S)
         2'b00: begin tgt0 = 4'b0001; tgt1 = 4'b0010; end
         2'b01: begin tgt0 = 4'b0001; tgt1 = 4'b0100; end
         2'b10: begin tgt0 = 4'b0010; tgt1 = 4'b0100; end
         2'b11: begin tgt0 = 4'b0001; tgt1 = 4'b1000; end
         default: begin tgt0 = 4'b0001; tgt1 = 4'b0010; end
      endcase
   end

   // Handshake: a beat is taken only when both of its target slots are free.
   always_comb begin
      free    = ~valid_q | sink_rdy;
      Z_ready = (((tgt0 | tgt1) & ~free) == '0);
      accept  = Z_valid && Z_ready;
   end

   // Per-sink next state: load beats drain, drain clears valid, data otherwise holds.
   always_comb begin
      for (int unsigned i = 0; i < NSINK; i++) begin
         load[i]    = accept && (tgt0[i] || tgt1[i]);
         valid_d[i] = valid_q[i];
         data_d[i]  = data_q[i];
         if (load[i]) begin
            valid_d[i] = 1'b1;
            data_d[i]  = tgt0[i] ? Z0_data : Z1_data;
         end else if (sink_rdy[i]) begin
            valid_d[i] = 1'b0;
         end
      end
   end

   // Sink registers; reset discards anything in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < NSINK; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int unsigned i = 0; i < NSINK; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign A_valid = valid_q[0];
   assign B_valid = valid_q[1];
   assign C_valid = valid_q[2];
   assign D_valid = valid_q[3];
   assign A_data  = data_q[0];
   assign B_data  = data_q[1];
   assign C_data  = data_q[2];
   assign D_data  = data_q[3];

endmodule

// File: tb/tb_datapath_dst_demux24.sv
// Directed and scoreboarded bench for datapath_dst_demux24.
module tb_datapath_dst_demux24;

   localparam int unsigned DWID   = 24;
   localparam int unsigned CH_NUM = 8;

   typedef logic [CH_NUM-1:0][DWID-1:0] lane_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] S = 2'b00;
   logic       Z_valid = 1'b0;
   logic       Z_ready;
   lane_t      Z0_data = '0;
   lane_t      Z1_data = '0;
   logic       A_valid, B_valid, C_valid, D_valid;
   logic [3:0] rdy = 4'b1111;
   lane_t      A_data, B_data, C_data, D_data;

   logic [3:0] vld_w;
   lane_t      dat_w [4];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   datapath_dst_demux24 #(.DWID(DWID), .CH_NUM(CH_NUM)) dut (
      .clk     (clk),
      .rst     (rst),
      .S       (S),
      .Z_valid (Z_valid),
      .Z_ready (Z_ready),
      .Z0_data (Z0_data),
      .Z1_data (Z1_data),
      .A_valid (A_valid),
      .B_valid (B_valid),
      .C_valid (C_valid),
      .D_valid (D_valid),
      .A_ready (rdy[0]),
      .B_ready (rdy[1]),
      .C_ready (rdy[2]),
      .D_ready (rdy[3]),
      .A_data  (A_data),
      .B_data  (B_data),
      .C_data  (C_data),
      .D_data  (D_data)
   );

   assign vld_w    = {D_valid, C_valid, B_valid, A_valid};
   assign dat_w[0] = A_data;
   assign dat_w[1] = B_data;
   assign dat_w[2] = C_data;
   assign dat_w[3] = D_data;

   // Lane pattern: channel k holds v with k in the upper byte.
   function automatic lane_t mk(input logic [DWID-1:0] v);
      lane_t r;
      for (int k = 0; k < CH_NUM; k++) r[k] = v ^ (DWID'(k) << 16);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      Z_valid = 1'b0;
      rdy     = 4'b1111;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if (vld_w !== 4'b0000) begin n_err++; $display("FAIL reset_valid got=%b exp=0000", vld_w); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (dat_w[i] !== lane_t'(0)) begin n_err++; $display("FAIL reset_data[%0d] got=%h exp=0", i, dat_w[i]); end
      end
      n_cmp++;
      if (Z_ready !== 1'b1) begin n_err++; $display("FAIL reset_zready got=%b exp=1", Z_ready); end
      #10 rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      S = 2'b00; Z0_data = mk(24'h000011); Z1_data = mk(24'h000022); Z_valid = 1'b1;
      #1;
      n_cmp++;
      if (Z_ready !== 1'b1) begin n_err++; $display("FAIL basic_zready got=%b exp=1", Z_ready); end
      step();
      Z_valid = 1'b0;
      n_cmp++;
      if (vld_w !== 4'b0011) begin n_err++; $display("FAIL basic_valid got=%b exp=0011", vld_w); end
      n_cmp++;
      if (A_data[0] !== 24'h000011) begin n_err++; $display("FAIL basic_A_ch0 got=%h exp=000011", A_data[0]); end
      n_cmp++;
      if (B_data[0] !== 24'h000022) begin n_err++; $display("FAIL basic_B_ch0 got=%h exp=000022", B_data[0]); end
      n_cmp++;
      if (B_data !== mk(24'h000022)) begin n_err++; $display("FAIL basic_B_lane got=%h exp=%h", B_data, mk(24'h000022)); end
      idle(2);
   endtask

   task automatic test_s_cycle();
      logic [3:0] exp_v [4];
      int         t0 [4];
      int         t1 [4];
      exp_v[0] = 4'b0011; t0[0] = 0; t1[0] = 1;
      exp_v[1] = 4'b0101; t0[1] = 0; t1[1] = 2;
      exp_v[2] = 4'b0110; t0[2] = 1; t1[2] = 2;
      exp_v[3] = 4'b1001; t0[3] = 0; t1[3] = 3;
      for (int i = 0; i < 4; i++) begin
         S = 2'(i); Z0_data = mk(24'h000100 + 24'(i)); Z1_data = mk(24'h000200 + 24'(i)); Z_valid = 1'b1;
         #1;
         n_cmp++;
         if (Z_ready !== 1'b1) begin n_err++; $display("FAIL cycle_zready[%0d] got=%b exp=1", i, Z_ready); end
         step();
         n_cmp++;
         if (vld_w !== exp_v[i]) begin n_err++; $display("FAIL cycle_valid[%0d] got=%b exp=%b", i, vld_w, exp_v[i]); end
         n_cmp++;
         if (dat_w[t0[i]] !== mk(24'h000100 + 24'(i))) begin n_err++; $display("FAIL cycle_z0[%0d] got=%h", i, dat_w[t0[i]]); end
         n_cmp++;
         if (dat_w[t1[i]] !== mk(24'h000200 + 24'(i))) begin n_err++; $display("FAIL cycle_z1[%0d] got=%h", i, dat_w[t1[i]]); end
      end
      idle(2);
   endtask

   task automatic test_stall();
      S = 2'b01; rdy = 4'b1011;
      Z0_data = mk(24'h000031); Z1_data = mk(24'h000032); Z_valid = 1'b1;
      #1;
      n_cmp++;
      if (Z_ready !== 1'b1) begin n_err++; $display("FAIL stall_first_zready got=%b exp=1", Z_ready); end
      step();
      Z0_data = mk(24'h000041); Z1_data = mk(24'h000042);
      #1;
      n_cmp++;
      if (Z_ready !== 1'b0) begin n_err++; $display("FAIL stall_zready got=%b exp=0", Z_ready); end
      step();
      n_cmp++;
      if (A_data !== mk(24'h000031)) begin n_err++; $display("FAIL stall_A_hold got=%h exp=%h", A_data, mk(24'h000031)); end
      n_cmp++;
      if (C_valid !== 1'b1 || C_data !== mk(24'h000032)) begin n_err++; $display("FAIL stall_C_hold got=%b/%h exp=1/%h", C_valid, C_data, mk(24'h000032)); end
      rdy = 4'b1111;
      #1;
      n_cmp++;
      if (Z_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_zready got=%b exp=1", Z_ready); end
      step();
      Z_valid = 1'b0;
      n_cmp++;
      if (A_valid !== 1'b1 || A_data !== mk(24'h000041)) begin n_err++; $display("FAIL stall_A_reload got=%b/%h", A_valid, A_data); end
      n_cmp++;
      if (C_valid !== 1'b1 || C_data !== mk(24'h000042)) begin n_err++; $display("FAIL stall_C_reload got=%b/%h", C_valid, C_data); end
      idle(2);
   endtask

   task automatic test_independent();
      S = 2'b11; rdy = 4'b0111;
      Z0_data = mk(24'h000051); Z1_data = mk(24'h000052); Z_valid = 1'b1;
      step();
      n_cmp++;
      if (D_valid !== 1'b1 || D_data !== mk(24'h000052)) begin n_err++; $display("FAIL indep_D_load got=%b/%h", D_valid, D_data); end
      S = 2'b10; Z0_data = mk(24'h000061); Z1_data = mk(24'h000062);
      #1;
      n_cmp++;
      if (Z_ready !== 1'b1) begin n_err++; $display("FAIL indep_zready got=%b exp=1", Z_ready); end
      step();
      Z_valid = 1'b0;
      n_cmp++;
      if (vld_w !== 4'b1110) begin n_err++; $display("FAIL indep_valid got=%b exp=1110", vld_w); end
      n_cmp++;
      if (B_data !== mk(24'h000061) || C_data !== mk(24'h000062)) begin n_err++; $display("FAIL indep_BC got=%h/%h", B_data, C_data); end
      n_cmp++;
      if (D_data !== mk(24'h000052)) begin n_err++; $display("FAIL indep_D_hold got=%h exp=%h", D_data, mk(24'h000052)); end
      idle(2);
   endtask

   task automatic test_reset_mid();
      S = 2'b00; Z0_data = mk(24'h000071); Z1_data = mk(24'h000072); Z_valid = 1'b1;
      step();
      rdy = 4'b1100;
      Z0_data = mk(24'h000081); Z1_data = mk(24'h000082);
      n_cmp++;
      if (vld_w !== 4'b0011) begin n_err++; $display("FAIL rstmid_pre got=%b exp=0011", vld_w); end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (vld_w !== 4'b0000) begin n_err++; $display("FAIL rstmid_async_valid got=%b exp=0000", vld_w); end
      n_cmp++;
      if (A_data !== lane_t'(0) || B_data !== lane_t'(0)) begin n_err++; $display("FAIL rstmid_data got=%h/%h exp=0", A_data, B_data); end
      step();
      n_cmp++;
      if (vld_w !== 4'b0000) begin n_err++; $display("FAIL rstmid_no_accept got=%b exp=0000", vld_w); end
      Z_valid = 1'b0;
      #1 rst = 1'b0;
      idle(2);
   endtask

   task automatic test_random();
      lane_t      q [4][$];
      logic       hold [4];
      lane_t      hold_d [4];
      int         t0, t1;
      logic       exp_zr;
      lane_t      got;
      for (int i = 0; i < 4; i++) hold[i] = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         Z_valid = ($urandom_range(0, 3) != 0);
         S       = 2'($urandom_range(0, 3));
         rdy     = 4'($urandom);
         for (int k = 0; k < CH_NUM; k++) begin
            Z0_data[k] = 24'($urandom);
            Z1_data[k] = 24'($urandom);
         end
         #2;
         case (S)
            2'b00: begin t0 = 0; t1 = 1; end
            2'b01: begin t0 = 0; t1 = 2; end
            2'b10: begin t0 = 1; t1 = 2; end
            default: begin t0 = 0; t1 = 3; end
         endcase
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (vld_w[i] !== (q[i].size() != 0)) begin n_err++; $display("FAIL rand_valid[%0d] cyc=%0d got=%b exp=%0d", i, cyc, vld_w[i], q[i].size()); end
            if (hold[i]) begin
               n_cmp++;
               if (vld_w[i] !== 1'b1 || dat_w[i] !== hold_d[i]) begin n_err++; $display("FAIL rand_stable[%0d] cyc=%0d got=%h exp=%h", i, cyc, dat_w[i], hold_d[i]); end
            end
         end
         exp_zr = ((q[t0].size() == 0) || rdy[t0]) && ((q[t1].size() == 0) || rdy[t1]);
         n_cmp++;
         if (Z_ready !== exp_zr) begin n_err++; $display("FAIL rand_zready cyc=%0d got=%b exp=%b", cyc, Z_ready, exp_zr); end
         for (int i = 0; i < 4; i++) begin
            if (rdy[i] && q[i].size() != 0) begin
               got = q[i].pop_front();
               n_cmp++;
               if (dat_w[i] !== got) begin n_err++; $display("FAIL rand_data[%0d] cyc=%0d got=%h exp=%h", i, cyc, dat_w[i], got); end
            end
            hold[i]   = vld_w[i] && !rdy[i];
            hold_d[i] = dat_w[i];
         end
         if (Z_valid && exp_zr) begin
            q[t0].push_back(Z0_data);
            q[t1].push_back(Z1_data);
         end
         step();
      end
      idle(2);
      n_cmp++;
      if (vld_w !== 4'b0000) begin n_err++; $display("FAIL rand_drained got=%b exp=0000", vld_w); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_s_cycle();
      test_stall();
      test_independent();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
